// File: rtl/dac_multi_if.sv
// Load and output signal bundle for the multi-channel PWM / sigma-delta DAC.
interface dac_multi_if #(
  parameter int unsigned RES = 7,
  parameter int unsigned CH  = 4
);
  localparam int unsigned N = RES + 1;

  logic [CH*N-1:0] dac_in;
  logic            conv;
  logic            mode;
  logic            ready;
  logic [CH-1:0]   dac_out;
  logic            frame_done;
  logic            overrun;

  modport master (
    output dac_in, conv, mode,
    input  ready, dac_out, frame_done, overrun
  );

  modport slave (
    input  dac_in, conv, mode,
    output ready, dac_out, frame_done, overrun
  );
endinterface

// File: rtl/dac_multi.sv
// Multi-channel 1-bit DAC: shared frame counter, double-buffered codes, per-channel
// PWM or first-order sigma-delta modulation selected per frame.
module dac_multi #(
  parameter int unsigned RES = 7,
  parameter int unsigned CH  = 4
) (
  input  logic      clk,
  input  logic      rst,
  dac_multi_if.slave bus
);
  localparam int unsigned N       = RES + 1;
  localparam logic [RES:0] CNT_MAX = '1;

  logic [RES:0]  r_cnt;
  logic          r_pending;
  logic          r_sh_mode;
  logic          r_act_mode;
  logic [RES:0]  r_shadow [CH];
  logic [RES:0]  r_active [CH];
  // Accumulator residue; the carry of each sum is what lands in r_dac_out.
  logic [RES:0]  r_acc    [CH];
  logic          r_ready;
  logic          r_frame_done;
  logic          r_overrun;
  logic [CH-1:0] r_dac_out;

  logic [RES:0]  w_cnt_nxt;
  logic          w_boundary;
  logic          w_accept;
  logic          w_xfer;
  logic          w_mode_chg;
  logic          w_pend_nxt;
  logic [N:0]    w_sum [CH];
  logic [CH-1:0] w_out_nxt;

  // Frame timing and load handshake decisions.
  always_comb begin
    w_cnt_nxt  = r_cnt + N'(1);
    w_boundary = (r_cnt == CNT_MAX);
    w_accept   = bus.conv && r_ready;
    w_xfer     = w_boundary && r_pending;
    w_mode_chg = w_xfer && (r_sh_mode != r_act_mode);
    w_pend_nxt = w_accept || (r_pending && !w_xfer);
  end

  // Per-channel modulator next values, computed with the code active this frame.
  always_comb begin
    w_out_nxt = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_active[i]};
      w_out_nxt[i] = r_act_mode ? w_sum[i][N] : (r_cnt < r_active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_sh_mode    <= 1'b0;
      r_act_mode   <= 1'b0;
      r_ready      <= 1'b1;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_dac_out    <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
        r_acc[i]    <= '0;
      end
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= (w_cnt_nxt == CNT_MAX);
      r_pending    <= w_pend_nxt;
      r_ready      <= !w_pend_nxt;
      r_dac_out    <= w_out_nxt;
      if (bus.conv && !r_ready) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_sh_mode <= bus.mode;
        for (int unsigned i = 0; i < CH; i++) begin
          r_shadow[i] <= bus.dac_in[i*N +: N];
        end
      end
      if (w_xfer) begin
        r_act_mode <= r_sh_mode;
        for (int unsigned i = 0; i < CH; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      // A mode switch restarts modulation from a clean accumulator; code-only updates keep the residue.
      for (int unsigned i = 0; i < CH; i++) begin
        if (w_mode_chg) begin
          r_acc[i] <= '0;
        end else if (r_act_mode) begin
          r_acc[i] <= w_sum[i][RES:0];
        end
      end
    end
  end

  assign bus.ready      = r_ready;
  assign bus.dac_out    = r_dac_out;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
endmodule

// File: doc/dac_multi.md
DAC_MULTI -- requirements
Module: dac_multi

Interface
REQ-001 Parameter RES, default 7, meaning MSB index of each channel code; code width N = RES+1.
REQ-002 Parameter CH, default 4, meaning number of independent output channels (1..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low (asserted when 0, sampled on clk rising edge).
REQ-005 dac_in  input  CH*N  packed channel codes; channel i occupies bits [i*N+RES : i*N].
REQ-006 conv  input  1  load request; samples all of dac_in and mode in one cycle.
REQ-007 mode  input  1  0 = PWM, 1 = first-order sigma-delta; captured with conv.
REQ-008 ready  output  1  high when the shadow register is empty and conv will be accepted.
REQ-009 dac_out  output  CH  registered 1-bit modulated output per channel.
REQ-010 frame_done  output  1  one-cycle pulse on the last cycle of each frame.
REQ-011 overrun  output  1  sticky flag; set when conv arrives while ready is low.

Function
REQ-012 Frame counter cnt, N bits, SHALL increment every cycle and wrap 2^N-1 -> 0; a frame is 2^N cycles.
REQ-013 frame_done SHALL be high exactly in cycles where cnt == 2^N-1.
REQ-014 conv with ready high SHALL load shadow codes and shadow mode on that edge and set pending; ready SHALL drop the next cycle.
REQ-015 conv with ready low SHALL leave the shadow unchanged (data dropped) and set overrun.
REQ-016 On the edge where cnt == 2^N-1 and pending is set, active codes and active mode SHALL take the shadow values and pending SHALL clear; ready SHALL rise the next cycle.
REQ-017 conv with ready high in the frame_done cycle: load shadow on that edge; the transfer to active waits for the next frame boundary (no same-edge bypass).
REQ-018 PWM mode: dac_out[i] SHALL register (cnt < active[i]); one cycle latency from cnt to output.
REQ-019 PWM duty: code 0 -> constant 0; code k -> exactly k high cycles per frame, contiguous from frame start; code 2^N-1 -> 2^N-1 high cycles per frame.
REQ-020 Sigma-delta mode: per-channel accumulator acc[i], N+1 bits; each cycle acc[i] <= {1'b0, acc[i][RES:0]} + active[i]; dac_out[i] SHALL register the carry bit acc[i][N] of the sum.
REQ-021 Sigma-delta average: over any 2^N aligned cycles the count of high outputs on channel i SHALL equal active[i].
REQ-022 Accumulators SHALL clear to 0 on every mode change at a frame boundary; they are not cleared on a code-only change.
REQ-023 All channels SHALL share cnt, mode and the load handshake; channels differ only in code and accumulator.
REQ-024 Arithmetic unsigned throughout; no saturation is required since codes cannot exceed 2^N-1.

Reset
REQ-025 With rst low at a rising edge: cnt=0, acc=0, active codes=0, active mode=0 (PWM), shadow=0, pending=0.
REQ-026 Output reset values: dac_out=0, frame_done=0, overrun=0, ready=1 (first cycle after rst release).
REQ-027 Reset mid-frame SHALL abort the frame and discard any pending shadow; the first frame after release starts at cnt=0.
REQ-028 overrun SHALL clear only on reset.

Verification
REQ-029 RES=7, CH=2, PWM: conv with ch0=0xE6, ch1=0x00 -> after the next boundary, ch0 high 230 of 256 cycles per frame, ch1 constantly 0.
REQ-030 PWM codes 0xFF and 0x01 -> 255 high / 1 low per frame and 1 high / 255 low per frame respectively, with the high interval starting at cnt=0 (+1 cycle latency).
REQ-031 Sigma-delta, code 0x80 -> output alternates 0,1 every cycle; code 0x40 -> one high per 4 cycles; exactly 128 and 64 highs per 256-cycle window.
REQ-032 Two conv pulses within one frame -> second dropped, overrun=1 and stays 1; active holds the first code after the boundary; ready returns high one cycle after the boundary.
REQ-033 conv in the frame_done cycle -> new code becomes active only at the following boundary (2^N cycles later); ready is low throughout that wait.
REQ-034 rst low for one cycle mid-frame with pending set -> all outputs 0, ready=1, overrun=0, pending discarded, cnt restarts from 0.
